// File: rtl/bus_router_if.sv
// -----------------------------------------------------------------------------
// bus_router_if
// Bundles the upstream request/response stream and the shared target-side bus
// of bus_router into one interface.
//
// Parameters:
//   NUM_SLAVES  number of target ports
//   DATA_WIDTH  data width; strobes are DATA_WIDTH/8 bits
//
// Modports:
//   master : the environment around the router. It drives the request stream
//            (memory_valid/instr/addr/wdata/wstrb) and the target responses
//            (slv_rdata/slv_ready). It observes everything else.
//   slave  : the router itself. It accepts the request stream, drives the
//            response (memory_rdata/ready/error) and the shared target bus.
// -----------------------------------------------------------------------------
interface bus_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Upstream request / response
  logic                           memory_valid;
  logic                           memory_instr;
  logic [31:0]                    memory_addr;
  logic [DATA_WIDTH-1:0]          memory_wdata;
  logic [STRB_WIDTH-1:0]          memory_wstrb;
  logic [DATA_WIDTH-1:0]          memory_rdata;
  logic                           memory_ready;
  logic                           memory_error;

  // Target side: one-hot valid, shared request fields, per-target response
  logic [NUM_SLAVES-1:0]          slv_valid;
  logic                           slv_instr;
  logic [31:0]                    slv_addr;
  logic [DATA_WIDTH-1:0]          slv_wdata;
  logic [STRB_WIDTH-1:0]          slv_wstrb;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata;
  logic [NUM_SLAVES-1:0]          slv_ready;

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output slv_rdata, slv_ready,
    input  memory_rdata, memory_ready, memory_error,
    input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb
  );

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  slv_rdata, slv_ready,
    output memory_rdata, memory_ready, memory_error,
    output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb
  );
endinterface

// File: rtl/bus_router.sv
// -----------------------------------------------------------------------------
// bus_router
// Routes a single master request stream to NUM_SLAVES targets through a
// programmable address map. The request is registered onto a shared target
// bus, and routing stays locked to the selected target until it responds.
// Unmapped accesses are answered with an error response.
//
// Optional feature (macro BUS_TIMEOUT_EN): a watchdog that turns a target
// silent for TIMEOUT_CYCLES request/wait cycles into an error response.
//
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    bus_router_if.slave
//            memory_*  : request in (valid/instr/addr/wdata/wstrb),
//                        response out (rdata/ready/error)
//            slv_*     : one-hot slv_valid plus shared registered request
//                        fields out, packed per-target rdata/ready in
// -----------------------------------------------------------------------------
module bus_router #(
  parameter int                       NUM_SLAVES     = 4,
  parameter int                       DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = {32'h8000_0000, 32'h1000_0000,
                                                        32'h0200_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLV_TOP        = {32'h9000_0000, 32'h1000_1000,
                                                        32'h0200_C000, 32'h0001_0000},
  parameter bit                       REBASE         = 1'b1,
  parameter int                       TIMEOUT_CYCLES = 1024
) (
  input logic       clock,
  input logic       reset,
  bus_router_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ERR
  } state_t;

  state_t                  state;
  logic [SEL_W-1:0]        sel;
  // In ERR the first cycle is silent; err_resp marks the response cycle.
  logic                    err_resp;

  logic [NUM_SLAVES-1:0]   slv_valid_q;
  logic                    slv_instr_q;
  logic [31:0]             slv_addr_q;
  logic [DATA_WIDTH-1:0]   slv_wdata_q;
  logic [STRB_WIDTH-1:0]   slv_wstrb_q;

`ifdef BUS_TIMEOUT_EN
  logic [15:0]             tmo_cnt;
`else
  // Watchdog limit has no consumer in this build.
  logic                    unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // ---------------------------------------------------------------------------
  // Address decode. Scanning from the top index down lets the lowest matching
  // index overwrite the others, so it wins on overlapping windows.
  // ---------------------------------------------------------------------------
  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic [31:0]             hit_base;
  logic [31:0]             fwd_addr;

  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise a
    // path that skips the assignment infers a latch.
    hit        = 1'b0;
    hit_idx    = '0;
    hit_base   = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.memory_addr >= SLV_BASE[32*i +: 32] &&
          bus.memory_addr <  SLV_TOP[32*i +: 32]) begin
        hit      = 1'b1;
        hit_idx  = SEL_W'(i);
        hit_base = SLV_BASE[32*i +: 32];
      end
    end
    hit_onehot[hit_idx] = hit;
    // Subtraction wraps modulo 2^32 by construction.
    fwd_addr = REBASE ? (bus.memory_addr - hit_base) : bus.memory_addr;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered target bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state       <= IDLE;
      sel         <= '0;
      err_resp    <= 1'b0;
      slv_valid_q <= '0;
      slv_instr_q <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      slv_wstrb_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Requests are only accepted here; anything arriving in another
          // state is a protocol violation and is dropped.
          if (bus.memory_valid) begin
            if (hit) begin
              sel         <= hit_idx;
              slv_valid_q <= hit_onehot;
              slv_instr_q <= bus.memory_instr;
              slv_addr_q  <= fwd_addr;
              slv_wdata_q <= bus.memory_wdata;
              slv_wstrb_q <= bus.memory_wstrb;
`ifdef BUS_TIMEOUT_EN
              tmo_cnt     <= '0;
`endif
              state       <= REQ;
            end else begin
              state       <= ERR;
            end
          end
        end

        REQ, WAIT: begin
          slv_valid_q <= '0;
          // A ready from the selected target takes priority over expiry.
          if (bus.slv_ready[sel]) begin
            state <= IDLE;
`ifdef BUS_TIMEOUT_EN
          end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            state   <= WAIT;
`else
          end else begin
            state <= WAIT;
`endif
          end
        end

        ERR: begin
          if (!err_resp) begin
            err_resp <= 1'b1;
          end else begin
            err_resp <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response path. While a target is selected its ready/rdata pass straight
  // through so the router adds no response latency; all other targets'
  // strobes never reach the master.
  // ---------------------------------------------------------------------------
  logic                  mem_ready;
  logic                  mem_error;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    case (state)
      REQ, WAIT: begin
        mem_ready = bus.slv_ready[sel];
        mem_rdata = bus.slv_rdata[sel*DATA_WIDTH +: DATA_WIDTH];
      end
      ERR: begin
        mem_ready = err_resp;
        mem_error = err_resp;
      end
      default: ;
    endcase
  end

  assign bus.memory_ready = mem_ready;
  assign bus.memory_error = mem_error;
  assign bus.memory_rdata = mem_rdata;

  assign bus.slv_valid    = slv_valid_q;
  assign bus.slv_instr    = slv_instr_q;
  assign bus.slv_addr     = slv_addr_q;
  assign bus.slv_wdata    = slv_wdata_q;
  assign bus.slv_wstrb    = slv_wstrb_q;

endmodule

// File: tb/tb_bus_router.sv
// -----------------------------------------------------------------------------
// tb_bus_router
// Self-checking bench for bus_router with the default 4-target address map.
// Directed vectors come from a table; random transactions are checked against
// a transaction-level reference (address-window lookup plus cycle offsets).
// Define BUS_TIMEOUT_EN for both files to exercise the watchdog (limit 8).
// -----------------------------------------------------------------------------
module tb_bus_router;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic clk;
  logic rst_n;

  bus_router_if #(.NUM_SLAVES(4), .DATA_WIDTH(32)) bus ();

  bus_router #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference address map.
  logic [31:0] base_tab [4] = '{32'h0000_0000, 32'h0200_0000, 32'h1000_0000, 32'h8000_0000};
  logic [31:0] top_tab  [4] = '{32'h0001_0000, 32'h0200_C000, 32'h1000_1000, 32'h9000_0000};

  logic [31:0] last_saddr;
  logic [31:0] last_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= base_tab[i] && a < top_tab[i]) return i;
    return -1;
  endfunction

  // Drive one request and check every cycle until the response is over.
  // delay = cycles after the slv_valid cycle at which the target answers.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr,
                         input int delay, input logic [31:0] rdata,
                         input int exp_idx, input logic [31:0] exp_saddr,
                         input bit noise);
    logic [3:0] oh;
    // Request cycle: stray readies in IDLE must not reach the master.
    bus.memory_valid = 1'b1;
    bus.memory_addr  = addr;
    bus.memory_wdata = wdata;
    bus.memory_wstrb = wstrb;
    bus.memory_instr = instr;
    bus.slv_ready    = 4'($urandom);
    bus.slv_rdata    = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check("idle_ready", bus.memory_ready, 1'b0);
    next_cycle();
    bus.memory_valid = 1'b0;
    bus.memory_addr  = $urandom;
    bus.memory_wdata = $urandom;
    bus.slv_ready    = '0;

    if (exp_idx < 0) begin
      #1;
      check("unmapped_valid_t1", bus.slv_valid, 4'b0);
      check("unmapped_ready_t1", bus.memory_ready, 1'b0);
      next_cycle();
      #1;
      check("unmapped_ready", bus.memory_ready, 1'b1);
      check("unmapped_error", bus.memory_error, 1'b1);
      check("unmapped_rdata", bus.memory_rdata, 32'h0);
      check("unmapped_valid_t2", bus.slv_valid, 4'b0);
      check("held_addr", bus.slv_addr, last_saddr);
      check("held_wdata", bus.slv_wdata, last_wdata);
      next_cycle();
      #1;
      check("unmapped_after", bus.memory_ready, 1'b0);
    end else begin
      oh = 4'b0001 << exp_idx;
      for (int k = 0; k <= delay; k++) begin
        bus.slv_ready = ((k == delay) ? oh : 4'b0) | ((noise && k < delay) ? ~oh : 4'b0);
        for (int j = 0; j < 4; j++)
          bus.slv_rdata[32*j +: 32] = (j == exp_idx) ? rdata : 32'hAAAA_5555;
        // A request while busy must be dropped.
        bus.memory_valid = noise && (k == 1);
        bus.memory_addr  = 32'h1000_0000;
        #1;
        check("slv_valid", bus.slv_valid, (k == 0) ? oh : 4'b0);
        check("mem_ready", bus.memory_ready, (k == delay) ? 1'b1 : 1'b0);
        if (k == 0) begin
          check("slv_addr", bus.slv_addr, exp_saddr);
          check("slv_wdata", bus.slv_wdata, wdata);
          check("slv_wstrb", bus.slv_wstrb, wstrb);
          check("slv_instr", bus.slv_instr, instr);
        end
        if (k == delay) begin
          check("mem_rdata", bus.memory_rdata, rdata);
          check("mem_error", bus.memory_error, 1'b0);
        end
        next_cycle();
      end
      bus.memory_valid = 1'b0;
      bus.slv_ready    = '0;
      #1;
      check("done_ready", bus.memory_ready, 1'b0);
      check("done_valid", bus.slv_valid, 4'b0);
      check("done_addr_held", bus.slv_addr, exp_saddr);
      last_saddr = exp_saddr;
      last_wdata = wdata;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          delay;
    logic [31:0] rdata;
    int          exp_idx;
    logic [31:0] exp_saddr;
    bit          noise;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{32'h1000_0004, 32'h0,         4'h0, 1'b0, 0, 32'hDEAD_BEEF,  2, 32'h0000_0004, 1'b0};
    vecs[1]  = '{32'h8000_0010, 32'h1234_5678, 4'hF, 1'b0, 5, 32'h0,          3, 32'h0000_0010, 1'b0};
    vecs[2]  = '{32'h4000_0000, 32'h0,         4'h0, 1'b0, 0, 32'h0,         -1, 32'h0,         1'b0};
    vecs[3]  = '{32'h0200_0020, 32'h0,         4'h0, 1'b0, 4, 32'h1111_2222,  1, 32'h0000_0020, 1'b1};
    vecs[4]  = '{32'h0000_FFFF, 32'hCAFE_0001, 4'h3, 1'b0, 1, 32'h5A5A_5A5A,  0, 32'h0000_FFFF, 1'b0};
    vecs[5]  = '{32'h0001_0000, 32'h0,         4'h0, 1'b0, 0, 32'h0,         -1, 32'h0,         1'b0};
    vecs[6]  = '{32'h0200_BFFF, 32'h0,         4'h0, 1'b1, 2, 32'h0F0F_0F0F,  1, 32'h0000_BFFF, 1'b1};
    vecs[7]  = '{32'h0200_C000, 32'h0,         4'h0, 1'b0, 0, 32'h0,         -1, 32'h0,         1'b0};
    vecs[8]  = '{32'h8FFF_FFFF, 32'h7777_8888, 4'h8, 1'b0, 3, 32'h1357_9BDF,  3, 32'h0FFF_FFFF, 1'b0};
    vecs[9]  = '{32'h9000_0000, 32'h0,         4'h0, 1'b0, 0, 32'h0,         -1, 32'h0,         1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0,         4'h0, 1'b0, 0, 32'h0,         -1, 32'h0,         1'b0};
    // Ready on the last cycle before the watchdog would expire.
    vecs[11] = '{32'h0000_0000, 32'h0,         4'h0, 1'b1, 7, 32'h2468_ACE0,  0, 32'h0000_0000, 1'b1};

    // Reset with inputs active: all outputs must be zero.
    rst_n            = 1'b0;
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    bus.slv_rdata    = {4{32'hFFFF_FFFF}};
    bus.slv_ready    = 4'hF;
    last_saddr       = '0;
    last_wdata       = '0;
    #2;
    check("rst_slv_valid", bus.slv_valid, 4'b0);
    check("rst_slv_addr", bus.slv_addr, 32'h0);
    check("rst_slv_wdata", bus.slv_wdata, 32'h0);
    check("rst_slv_wstrb", bus.slv_wstrb, 4'h0);
    check("rst_slv_instr", bus.slv_instr, 1'b0);
    check("rst_ready", bus.memory_ready, 1'b0);
    check("rst_error", bus.memory_error, 1'b0);
    check("rst_rdata", bus.memory_rdata, 32'h0);
    next_cycle();
    next_cycle();
    rst_n         = 1'b1;
    bus.slv_ready = '0;
    next_cycle();

    // Directed table.
    foreach (vecs[i])
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr, vecs[i].delay,
              vecs[i].rdata, vecs[i].exp_idx, vecs[i].exp_saddr, vecs[i].noise);

    // Reset while waiting: response discarded, late ready ignored.
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0200_0004;
    next_cycle();
    bus.memory_valid = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.memory_ready, 1'b0);
    check("midrst_valid", bus.slv_valid, 4'b0);
    check("midrst_addr", bus.slv_addr, 32'h0);
    next_cycle();
    rst_n         = 1'b1;
    bus.slv_ready = 4'b0010;
    #1;
    check("midrst_late_ready", bus.memory_ready, 1'b0);
    next_cycle();
    #1;
    check("midrst_late_ready2", bus.memory_ready, 1'b0);
    bus.slv_ready = '0;
    last_saddr    = '0;
    last_wdata    = '0;
    run_txn(32'h0200_0000, 32'h0, 4'h0, 1'b0, 1, 32'h600D_F00D, 1, 32'h0, 1'b0);

`ifdef BUS_TIMEOUT_EN
    // Slave 0 never answers: 8 request/wait cycles, one ERR cycle, response.
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h0000_0100;
    next_cycle();
    bus.memory_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("tmo_ready", bus.memory_ready, (k == 9) ? 1'b1 : 1'b0);
      check("tmo_error", bus.memory_error, (k == 9) ? 1'b1 : 1'b0);
      if (k == 9) check("tmo_rdata", bus.memory_rdata, 32'h0);
      next_cycle();
    end
    bus.slv_ready = 4'b0001;
    #1;
    check("tmo_late_ready", bus.memory_ready, 1'b0);
    next_cycle();
    bus.slv_ready = '0;
    last_saddr    = 32'h0000_0100;
`else
    // Without the watchdog a slow target is simply waited for.
    run_txn(32'h1000_0FFC, 32'h0, 4'h0, 1'b0, 30, 32'h0BAD_CAFE, 2, 32'h0000_0FFC, 1'b1);
`endif

    // Random transactions against the address-window reference.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          idx;
      int          s;
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom;
      end else begin
        s = $urandom_range(0, 3);
        a = base_tab[s] + ($urandom % (top_tab[s] - base_tab[s]));
      end
      idx = model_decode(a);
      run_txn(a, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 6), $urandom,
              idx, (idx < 0) ? 32'h0 : a - base_tab[idx], 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_router.md
Name: bus_router

Overview:
- Parametrised successor to the fixed four-target SoC address decoder.
- Routes one master request stream (arbiter output) to NUM_SLAVES targets through a programmable address map.
- Registers the request and locks routing until the selected target responds.
- Ignores stray ready pulses from unselected targets; answers unmapped accesses with an error; optional timeout watchdog.

Parameters:
- NUM_SLAVES, 4, number of target ports (1..16)
- DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8
- SLV_BASE, {0x00000000,0x02000000,0x10000000,0x80000000}, packed NUM_SLAVES*32 base addresses, slave i at bits [32*i+:32]
- SLV_TOP, {0x00010000,0x0200C000,0x10001000,0x90000000}, packed exclusive top addresses
- REBASE, 1, 1: forward addr minus base of selected slave; 0: forward raw addr
- TIMEOUT_CYCLES, 1024, watchdog limit (only with BUS_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- memory_valid  in  1  request strobe, one-cycle pulse
- memory_instr  in  1  instruction-fetch flag
- memory_addr  in  32  byte address
- memory_wdata  in  DATA_WIDTH  write data
- memory_wstrb  in  DATA_WIDTH/8  byte strobes; 0 = read
- memory_rdata  out  DATA_WIDTH  response data
- memory_ready  out  1  response strobe, one cycle
- memory_error  out  1  qualifies memory_ready: unmapped or timed-out access
- slv_valid  out  NUM_SLAVES  one-hot request strobe
- slv_instr  out  1  shared, registered
- slv_addr  out  32  shared, registered, rebased per REBASE
- slv_wdata  out  DATA_WIDTH  shared, registered
- slv_wstrb  out  DATA_WIDTH/8  shared, registered
- slv_rdata  in  NUM_SLAVES*DATA_WIDTH  packed per-slave read data
- slv_ready  in  NUM_SLAVES  per-slave response strobe

Behaviour:
- Reset (reset=0, async): state IDLE, sel=0. slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb are 0. memory_ready, memory_error, memory_rdata are 0.
- Decode: slave i hits when SLV_BASE[i] <= addr < SLV_TOP[i], unsigned 32-bit. Lowest index wins on overlap. No hit = unmapped.
- States: IDLE, REQ, WAIT, ERR.
- IDLE + memory_valid + hit i:
  - Latch instr/addr/wdata/wstrb and sel=i.
  - Go to REQ; slv_valid[i]=1 for exactly one cycle (the REQ cycle), then go to WAIT.
- IDLE + memory_valid + unmapped: go to ERR. Next cycle: memory_ready=1, memory_error=1, memory_rdata=0. Then back to IDLE.
- WAIT (and REQ):
  - memory_ready = slv_ready[sel]; memory_rdata = slv_rdata[sel]; memory_error=0. Combinational, zero added response latency.
  - On slv_ready[sel] go to IDLE.
  - Ready arriving in the REQ cycle itself is honoured.
- Minimum latency: valid at cycle t; target sees slv_valid at t+1; a same-cycle target gives memory_ready at t+1.
- slv_ready[j], j!=sel, is ignored in every state. Any slv_ready in IDLE/ERR is ignored. memory_ready=0 in IDLE.
- memory_valid outside IDLE is dropped, no effect (master protocol violation). memory_valid in the same cycle memory_ready is asserted is also dropped.
- Shared slv_* buses hold their last latched values between requests.
- Async reset mid-transaction: returns to IDLE at once. The pending response is discarded; a late slv_ready is ignored.
- Unused rebase arithmetic is modulo 2^32.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - 16-bit counter cleared on entering REQ, incremented each REQ/WAIT cycle.
  - When count reaches TIMEOUT_CYCLES-1 without slv_ready[sel], go to ERR: memory_ready=1, memory_error=1, rdata=0 next cycle, then IDLE.
  - A later slv_ready from that slave is ignored.
  - slv_ready in the same cycle as expiry wins: normal response, no error.
- Not defined: no counter; WAIT holds indefinitely until slv_ready[sel]. memory_error is asserted only for unmapped accesses.

Test Plan:
- Read 0x10000004 (REBASE=1), slave 2 returns ready+0xDEADBEEF in its valid cycle -> slv_valid=0b0100 one cycle, slv_addr=0x4, memory_ready one cycle later with rdata 0xDEADBEEF, error=0.
- Write 0x80000010 wdata 0x12345678 wstrb 0xF, slave 3 ready after 5 cycles -> slv_wstrb=0xF, slv_addr=0x10, memory_ready exactly when slv_ready[3], state IDLE next cycle.
- Access 0x40000000 -> memory_ready=1, memory_error=1, rdata=0 two cycles after valid; no slv_valid bit ever set.
- Slave 1 selected; slave 0 pulses ready with 0xAAAA5555 while waiting -> memory_ready stays 0 until slv_ready[1].
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave 0 never ready -> memory_ready+error after 8 wait cycles; a late slv_ready[0] produces no response.
- reset driven low while in WAIT, then released; slave asserts ready -> memory_ready stays 0; a fresh request to 0x02000000 completes normally.
